// File: rtl/instr_fetch_if.sv
// Program-load and instruction-stream signals between the sequencer and its environment.
// The sequencer uses the slave modport; the environment (loader plus core) uses master.
interface instr_fetch_if #(
  parameter int unsigned AddrW = 4
);
  logic             clear;
  logic             load_valid;
  logic [5:0]       load_data;
  logic             load_ready;
  logic             start;
  logic             cjump;
  logic [5:0]       instr;
  logic             instr_valid;
  logic [AddrW-1:0] pc;
  logic             halted;

  modport slave (
    input  clear, load_valid, load_data, start, cjump,
    output load_ready, instr, instr_valid, pc, halted
  );

  modport master (
    output clear, load_valid, load_data, start, cjump,
    input  load_ready, instr, instr_valid, pc, halted
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction sequencer: a program is loaded into a flop array over valid/ready, then streamed
// one 6-bit word per clock to the core, with jumps redirected by the core's cjump.
module instr_fetch #(
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = 4,
  parameter bit          Wrap  = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  instr_fetch_if.slave bus_io
);

  localparam logic [AddrW:0] LenDepth = Depth[AddrW:0];

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] pc_q, pc_d;
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   len_q, len_d;
  logic [5:0]       mem_q [Depth];

  logic             load_ready;
  logic             accept;
  logic             wr_en;
  logic [5:0]       cur_word;
  logic [AddrW-1:0] target;

  assign load_ready = (state_q == StIdle) && (len_q < LenDepth);
  assign accept     = bus_io.load_valid && load_ready;
  // clear wins over a simultaneous load, so the word is not written.
  assign wr_en      = accept && !bus_io.clear;
  assign cur_word   = mem_q[pc_q];
  // The jump operand is the word currently presented to the core.
  assign target     = cur_word[AddrW-1:0];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    len_d    = len_q;
    if (bus_io.clear) begin
      state_d  = StIdle;
      pc_d     = '0;
      wr_ptr_d = '0;
      len_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            len_d    = len_q + 1'b1;
          end
          if (bus_io.start && (len_q != '0 || accept)) begin
            state_d = StRun;
            pc_d    = '0;
          end
        end
        StRun: begin
          if (bus_io.start) begin
            pc_d = '0;
          end else if (bus_io.cjump) begin
            if ({1'b0, target} < len_q) pc_d = target;
            else                       state_d = StHalt;
          end else if ({1'b0, pc_q} == len_q - 1'b1) begin
            if (Wrap) pc_d = '0;
            else      state_d = StHalt;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
        StHalt: begin
          if (bus_io.start) begin
            state_d = StRun;
            pc_d    = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      wr_ptr_q <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      len_q    <= len_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= bus_io.load_data;
    end
  end

  always_comb begin
    bus_io.load_ready  = load_ready;
    bus_io.instr       = (state_q == StRun) ? cur_word : 6'b0;
    bus_io.instr_valid = (state_q == StRun);
    bus_io.pc          = pc_q;
    bus_io.halted      = (state_q == StHalt);
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a non-wrapping and a wrapping instance share one stimulus stream and
// are compared every cycle against a queue-based model of the loaded program.
module tb_instr_fetch;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  instr_fetch_if #(.AddrW(4)) bus0 ();
  instr_fetch_if #(.AddrW(4)) bus1 ();

  instr_fetch #(.Depth(16), .AddrW(4), .Wrap(1'b0)) u_dut0 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus_io (bus0)
  );

  instr_fetch #(.Depth(16), .AddrW(4), .Wrap(1'b1)) u_dut1 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus_io (bus1)
  );

  typedef enum int {MIdle, MRun, MHalt} mode_e;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [5:0] prog [$];
  mode_e      mode [2];
  int unsigned mpc [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_one(input int i, input logic lr, input logic [5:0] ins, input logic v,
                           input logic [3:0] pc, input logic h);
    logic [5:0] exp_instr;
    exp_instr = (mode[i] == MRun) ? prog[mpc[i]] : 6'h00;
    chk($sformatf("w%0d.load_ready", i), 32'(lr), 32'(mode[i] == MIdle && prog.size() < 16));
    chk($sformatf("w%0d.instr", i), 32'(ins), 32'(exp_instr));
    chk($sformatf("w%0d.instr_valid", i), 32'(v), 32'(mode[i] == MRun));
    chk($sformatf("w%0d.halted", i), 32'(h), 32'(mode[i] == MHalt));
    if (mode[i] != MIdle) chk($sformatf("w%0d.pc", i), 32'(pc), mpc[i]);
  endtask

  task automatic check_outputs();
    check_one(0, bus0.load_ready, bus0.instr, bus0.instr_valid, bus0.pc, bus0.halted);
    check_one(1, bus1.load_ready, bus1.instr, bus1.instr_valid, bus1.pc, bus1.halted);
  endtask

  task automatic drive(input logic clr, input logic lv, input logic [5:0] ld, input logic st,
                       input logic cj);
    bus0.clear = clr; bus0.load_valid = lv; bus0.load_data = ld; bus0.start = st;
    bus0.cjump = cj;
    bus1.clear = clr; bus1.load_valid = lv; bus1.load_data = ld; bus1.start = st;
    bus1.cjump = cj;
  endtask

  // One clock edge of the architectural behaviour, in terms of the program as a list of words.
  task automatic model_edge(input logic clr, input logic lv, input logic [5:0] ld,
                            input logic st, input logic cj);
    bit acc;
    int unsigned t;
    acc = !clr && mode[0] == MIdle && lv && prog.size() < 16;
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        mode[i] = MIdle;
        mpc[i]  = 0;
      end else begin
        case (mode[i])
          MIdle: if (st && (prog.size() > 0 || acc)) begin mode[i] = MRun; mpc[i] = 0; end
          MRun: begin
            if (st) mpc[i] = 0;
            else if (cj) begin
              t = prog[mpc[i]] % 16;
              if (t < prog.size()) mpc[i] = t;
              else mode[i] = MHalt;
            end else if (mpc[i] + 1 < prog.size()) mpc[i] = mpc[i] + 1;
            else if (i == 1) mpc[i] = 0;
            else mode[i] = MHalt;
          end
          MHalt: if (st) begin mode[i] = MRun; mpc[i] = 0; end
          default: mode[i] = MIdle;
        endcase
      end
    end
    if (clr) prog.delete();
    else if (acc) prog.push_back(ld);
  endtask

  task automatic step(input logic clr, input logic lv, input logic [5:0] ld, input logic st,
                      input logic cj);
    @(negedge clk_i);
    check_outputs();
    drive(clr, lv, ld, st, cj);
    @(posedge clk_i);
    model_edge(clr, lv, ld, st, cj);
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
  endtask

  task automatic load_word(input logic [5:0] w);
    step(1'b0, 1'b1, w, 1'b0, 1'b0);
  endtask

  // Reset is asserted between edges and checked before any edge can hide a slow response.
  task automatic apply_reset();
    @(negedge clk_i);
    #2;
    drive(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
    rst_ni = 1'b0;
    #1;
    prog.delete();
    for (int i = 0; i < 2; i++) begin mode[i] = MIdle; mpc[i] = 0; end
    check_outputs();
    chk("rst.pc0", 32'(bus0.pc), 32'd0);
    chk("rst.pc1", 32'(bus1.pc), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
    apply_reset();

    // Three-word program, no jumps: wrap0 halts after word 3, wrap1 loops.
    load_word(6'h01); load_word(6'h02); load_word(6'h03);
    step(1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
    idle_steps(6);
    // start in HALT replays from 0.
    step(1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
    idle_steps(2);

    // Fill to capacity and offer one more word.
    step(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
    for (int k = 0; k < 17; k++) load_word(6'($urandom_range(0, 63)));
    step(1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
    idle_steps(18);

    // Jump back to 0 from pc 1, then the out-of-range variant.
    step(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
    load_word(6'h10); load_word(6'h00); load_word(6'h20); load_word(6'h30);
    step(1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 6'h00, 1'b0, 1'b1);
    idle_steps(2);
    step(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
    load_word(6'h10); load_word(6'h0F); load_word(6'h20); load_word(6'h30);
    step(1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 6'h00, 1'b0, 1'b1);
    idle_steps(2);

    // Jump on the last word beats end-of-program; start & accept in one cycle.
    step(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
    load_word(6'h02); load_word(6'h05);
    step(1'b0, 1'b1, 6'h01, 1'b1, 1'b0);
    idle_steps(2);
    step(1'b0, 1'b0, 6'h00, 1'b0, 1'b1);
    idle_steps(6);

    // Reset mid-run, clear & start together, start with nothing loaded.
    apply_reset();
    step(1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
    load_word(6'h07);
    step(1'b1, 1'b0, 6'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
    idle_steps(1);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 399) == 0) apply_reset();
      step($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1, 6'($urandom_range(0, 63)),
           $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0);
    end

    @(negedge clk_i);
    check_outputs();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
